fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RV32I core: owns the program counter, drives the instruction memory's word-aligned read address, and buffers fetched words in a 2-entry queue feeding decode over a valid/ready handshake. It accepts PC redirects from execute (branches, jumps) and flushes wrong-path instructions. A misaligned redirect target produces a single flagged entry, then fetch halts until the next redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals current PC.
- imem_instr  input  32  instruction word returned combinationally for imem_addr, same cycle.
- redirect_valid  input  1  execute requests PC change this cycle.
- redirect_pc  input  32  new PC; sampled when redirect_valid=1.
- id_valid  output  1  head queue entry is presented to decode.
- id_ready  input  1  decode accepts the head entry.
- id_pc  output  32  PC of head entry.
- id_instr  output  32  instruction of head entry.
- id_misaligned  output  1  head entry marks an instruction-address-misaligned fetch.

## Operation
- State: pc (32b), state FSM, queue of 2 entries {pc, instr, misaligned}, count 0..2.
- imem_addr = pc at all times (combinational from register).
- id_valid = (count != 0) && !redirect_valid; id_* fields come from queue head (first-word-fall-through). Dequeue when id_valid && id_ready.
- FSM states:
  - RUN: enqueue when (count < 2 or dequeue this cycle) and !redirect_valid. Enqueue pushes {pc, imem_instr, 0}; pc <= pc + 4 (wraps modulo 2^32, 32'hFFFF_FFFC -> 0).
  - TRAP: enqueue {pc, 32'h0000_0013 (NOP), 1} under same space rule; pc unchanged; -> HALT on enqueue.
  - HALT: no enqueue; pc held; queue drains normally.
- Redirect (any state, highest priority after rst): queue flushed (count <= 0), pc <= redirect_pc, no enqueue, no dequeue this cycle. Next state RUN if redirect_pc[1:0]==0, else TRAP.
- Full queue with simultaneous dequeue: enqueue still permitted (count stays 2). Empty queue: id_valid=0, id_* hold last head storage contents (don't-care to decode).
- rst: pc <= RESET_PC, count <= 0, state <= RUN, queue storage cleared to 0. rst overrides redirect_valid. Reset mid-operation discards all queued entries.

## Timing
- Reset values (cycle after rst sampled high): imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0, id_misaligned=0, state RUN.
- Fetch latency: word fetched in cycle N appears on id_* in cycle N+1.
- Throughput: one instruction/cycle sustained with id_ready held high.
- Backpressure: with id_ready=0 the queue fills in 2 cycles; imem_addr then holds at the PC of the next unfetched word.
- Redirect penalty: redirect_valid at cycle N -> imem_addr=redirect_pc at N+1 -> id_valid with id_pc=redirect_pc at N+2.
- Misaligned redirect at N: entry with id_misaligned=1 valid at N+2; no further entries until next redirect.
- No combinational path from imem_instr to id_*; id_valid has a combinational path from redirect_valid only.

## Test plan
- Reset, RESET_PC=0, id_ready=1, memory word i = i -> id_pc sequence 0,4,8,... with id_instr 0,1,2,... one per cycle from cycle 1 after reset release.
- id_ready=0 for 5 cycles after stream starts -> count saturates at 2, imem_addr holds 8; release id_ready -> entries 0,4,8,12 delivered in order, no loss or duplication.
- redirect_valid with redirect_pc=32'h40 while queue full -> id_valid=0 that cycle, next cycle imem_addr=0x40, following cycle id_pc=0x40; flushed entries never presented.
- redirect_pc=32'h42 -> one entry id_pc=0x42, id_instr=0x00000013, id_misaligned=1; then id_valid=0 indefinitely; redirect to 0x80 resumes at 0x80.
- pc starts at 32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted with 2 queued entries and redirect_valid=1 same cycle -> next cycle id_valid=0, imem_addr=RESET_PC, state RUN.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory read port, execute redirect, decode handshake.
// master = fetch stage, slave = memory/execute/decode side.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_misaligned;

  modport master (
    output imem_addr, id_valid, id_pc, id_instr, id_misaligned,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_instr, id_misaligned,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch: PC owner feeding a 2-entry FWFT queue to decode; one-cycle fetch-to-decode latency.
// Stalls PC when the queue is full and undrained; redirects flush the queue.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  entry_t      q0, q1;
  entry_t      new_entry;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        deq;
  logic        enq;
  logic        can_enq;
  logic        pc_adv;
  logic        wr_head;

  assign bus.imem_addr     = pc;
  assign bus.id_valid      = (count != 2'd0) && !bus.redirect_valid;
  assign bus.id_pc         = q0.pc;
  assign bus.id_instr      = q0.instr;
  assign bus.id_misaligned = q0.misaligned;

  assign deq       = bus.id_valid && bus.id_ready;
  assign can_enq   = (count != 2'd2) || deq;
  assign count_nxt = count + {1'b0, enq} - {1'b0, deq};
  // New entry lands in the head slot when the queue is (or becomes) empty this cycle.
  assign wr_head   = (count == 2'd0) || ((count == 2'd1) && deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    enq                  = 1'b0;
    pc_adv               = 1'b0;
    new_entry.pc         = pc;
    new_entry.instr      = bus.imem_instr;
    new_entry.misaligned = 1'b0;
    if (bus.redirect_valid) begin
      state_nxt = (bus.redirect_pc[1:0] == 2'b00) ? RUN : TRAP;
    end else begin
      case (state)
        RUN: begin
          enq    = can_enq;
          pc_adv = can_enq;
        end
        TRAP: begin
          enq                  = can_enq;
          new_entry.instr      = NOP;
          new_entry.misaligned = 1'b1;
          if (can_enq) begin
            state_nxt = HALT;
          end
        end
        HALT: begin
          enq = 1'b0;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc;
      count <= 2'd0;
    end else begin
      if (deq) begin
        q0 <= q1;
      end
      if (enq) begin
        if (wr_head) begin
          q0 <= new_entry;
        end else begin
          q1 <= new_entry;
        end
      end
      if (pc_adv) begin
        pc <= pc + 32'd4;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with fixed expectations, then random traffic
// against a queue-based reference model. Memory word at byte address a is (a>>2)^mem_key.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_key = 32'h0;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = (bus.imem_addr >> 2) ^ mem_key;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = rdy;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0055;
    bus.id_ready       = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, 32'h0); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
    checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); end
    checks++; if (bus.id_misaligned !== 1'b0) begin errors++; $display("FAIL reset_id_mis: got %b want 0", bus.id_misaligned); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", bus.id_valid); end
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.id_valid); end
      checks++; if (bus.id_pc !== exp_pc || bus.id_instr !== 32'(i) || bus.id_misaligned !== 1'b0)
        begin errors++; $display("FAIL stream_entry[%0d]: got %h/%h/%b want %h/%h/0", i, bus.id_pc, bus.id_instr, bus.id_misaligned, exp_pc, 32'(i)); end
      checks++; if (bus.imem_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_pc + 32'd4); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (5) tick();
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr_hold: got %h want %h", bus.imem_addr, 32'h8); end
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %b/%h want 1/0", bus.id_valid, bus.id_pc); end
    bus.id_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * k) || bus.id_instr !== 32'(k))
        begin errors++; $display("FAIL bp_drain[%0d]: got %b/%h/%h want 1/%h/%h", k, bus.id_valid, bus.id_pc, bus.id_instr, 32'(4 * k), 32'(k)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n: got %b want 0", bus.id_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr_n1: got %h want %h", bus.imem_addr, 32'h40); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1: got %b want 0", bus.id_valid); end
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_instr !== 32'h10)
      begin errors++; $display("FAIL redir_head_n2: got %b/%h/%h want 1/40/10", bus.id_valid, bus.id_pc, bus.id_instr); end
    bus.id_ready = 1'b1;
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h44) begin errors++; $display("FAIL redir_next: got %b/%h want 1/44", bus.id_valid, bus.id_pc); end
  endtask

  task automatic test_misaligned();
    int bad;
    do_reset(1'b1);
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL mis_valid_n: got %b want 0", bus.id_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h42 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL mis_n1: got %h/%b want 42/0", bus.imem_addr, bus.id_valid); end
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h42 || bus.id_instr !== 32'h13 || bus.id_misaligned !== 1'b1)
      begin errors++; $display("FAIL mis_entry: got %b/%h/%h/%b want 1/42/13/1", bus.id_valid, bus.id_pc, bus.id_instr, bus.id_misaligned); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h42) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mis_halt: got %0d active cycles want 0", bad); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h80 || bus.id_instr !== 32'h20 || bus.id_misaligned !== 1'b0)
      begin errors++; $display("FAIL mis_resume: got %b/%h/%h/%b want 1/80/20/0", bus.id_valid, bus.id_pc, bus.id_instr, bus.id_misaligned); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc[i] || bus.id_instr !== (exp_pc[i] >> 2))
        begin errors++; $display("FAIL wrap[%0d]: got %b/%h/%h want 1/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, exp_pc[i], exp_pc[i] >> 2); end
      tick();
    end
  endtask

  task automatic test_reset_override();
    do_reset(1'b0);
    tick();
    tick();
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rstov_n1: got %b/%h want 0/0", bus.id_valid, bus.imem_addr); end
    tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_misaligned !== 1'b0)
      begin errors++; $display("FAIL rstov_run: got %b/%h/%b want 1/0/0", bus.id_valid, bus.id_pc, bus.id_misaligned); end
  endtask

  task automatic test_random();
    ent_t        mq[$];
    logic [31:0] mpc;
    logic [31:0] rpc;
    int          mmode;
    logic        r, rdy, exp_v;
    mem_key = $urandom;
    do_reset(1'b1);
    mpc   = 32'h0;
    mmode = 0;
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(11) == 0);
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(3) != 0);
      bus.redirect_valid = r;
      bus.redirect_pc    = rpc;
      bus.id_ready       = rdy;
      #1;
      exp_v = (mq.size() != 0) && !r;
      checks++; if (bus.imem_addr !== mpc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, bus.imem_addr, mpc); end
      checks++; if (bus.id_valid !== exp_v) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.id_valid, exp_v); end
      if (exp_v) begin
        checks++; if ({bus.id_pc, bus.id_instr, bus.id_misaligned} !== mq[0])
          begin errors++; $display("FAIL rnd_head[%0d]: got %h/%h/%b want %h/%h/%b", n, bus.id_pc, bus.id_instr, bus.id_misaligned, mq[0].pc, mq[0].instr, mq[0].mis); end
      end
      // mode 0 = fetching, 1 = owes one misaligned entry, 2 = stopped
      if (r) begin
        mq.delete();
        mpc   = rpc;
        mmode = (rpc[1:0] == 2'b00) ? 0 : 1;
      end else begin
        if (exp_v && rdy) void'(mq.pop_front());
        if (mmode != 2 && mq.size() < 2) begin
          if (mmode == 0) begin
            mq.push_back({mpc, (mpc >> 2) ^ mem_key, 1'b0});
            mpc = mpc + 32'd4;
          end else begin
            mq.push_back({mpc, 32'h0000_0013, 1'b1});
            mmode = 2;
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
